// File: rtl/slave_mem_loader_if.sv
// Slave RAM port of the HLS-generated design under test.
// The loader drives requests as master; the DUT memory answers as slave.
interface slave_mem_loader_if #(
    parameter int ADDR_W = 18
);
    logic              S_oe_ram;
    logic              S_we_ram;
    logic [ADDR_W-1:0] S_addr_ram;
    logic [31:0]       S_Wdata_ram;
    logic [6:0]        S_data_ram_size;
    logic [31:0]       Sout_Rdata_ram;
    logic              Sout_DataRdy;

    modport master (
        output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
        input  Sout_Rdata_ram, Sout_DataRdy
    );

    modport slave (
        input  S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
        output Sout_Rdata_ram, Sout_DataRdy
    );
endinterface

// File: rtl/slave_mem_loader.sv
// Preloads DUT memory from a byte stream, starts the DUT, times it to done,
// then streams the memory image back out word by word.
module slave_mem_loader #(
    parameter int NUM_WORDS = 32,
    parameter int ADDR_W    = 18,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 200000000,
    localparam int IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    slave_mem_loader_if.master    ram,
    output logic                  start_port,
    input  logic                  done_port,
    output logic                  rd_valid,
    output logic [31:0]           rd_data,
    output logic [IDX_W-1:0]      rd_index,
    input  logic                  rd_ready,
    output logic [31:0]           cycles,
    output logic                  timeout,
    output logic                  finished
);
    typedef enum logic [2:0] {
        IDLE, LOAD, WRITE, START, WAIT, RD_REQ, RD_OUT, FIN
    } state_t;

    localparam logic [IDX_W-1:0]  LAST = IDX_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       TMO  = 32'(TIMEOUT);

    state_t            state, nxt;
    logic [31:0]       word;
    logic [1:0]        bcnt;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       cyc;
    logic              tmo;
    logic [31:0]       rdata;
    logic              oe, we;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt        = state;
        byte_ready = 1'b0;
        oe         = 1'b0;
        we         = 1'b0;
        start_port = 1'b0;
        rd_valid   = 1'b0;
        finished   = 1'b0;
        case (state)
            IDLE:   if (go) nxt = LOAD;
            LOAD: begin
                byte_ready = 1'b1;
                if (byte_valid && bcnt == 2'd3) nxt = WRITE;
            end
            WRITE: begin
                we = 1'b1;
                if (ram.Sout_DataRdy) nxt = (idx == LAST) ? START : LOAD;
            end
            START: begin
                start_port = 1'b1;
                nxt        = WAIT;
            end
            // done wins over a timeout landing on the same cycle
            WAIT: begin
                if (done_port)       nxt = RD_REQ;
                else if (cyc == TMO) nxt = FIN;
            end
            RD_REQ: begin
                oe = 1'b1;
                if (ram.Sout_DataRdy) nxt = RD_OUT;
            end
            RD_OUT: begin
                rd_valid = 1'b1;
                if (rd_ready) nxt = (idx == LAST) ? FIN : RD_REQ;
            end
            FIN: begin
                finished = 1'b1;
                nxt      = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word  <= '0;
            bcnt  <= '0;
            idx   <= '0;
            cyc   <= '0;
            tmo   <= 1'b0;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    idx  <= '0;
                    bcnt <= '0;
                    cyc  <= '0;
                    tmo  <= 1'b0;
                end
                // little-endian assembly; bcnt wraps back to 0 after the 4th byte
                LOAD: if (byte_valid) begin
                    word[{bcnt, 3'b000} +: 8] <= byte_data;
                    bcnt <= bcnt + 2'd1;
                end
                WRITE:  if (ram.Sout_DataRdy && idx != LAST) idx <= idx + 1'b1;
                START:  cyc <= 32'd1;
                WAIT: begin
                    if (done_port)       idx <= '0;
                    else if (cyc == TMO) tmo <= 1'b1;
                    else if (cyc != '1)  cyc <= cyc + 32'd1;
                end
                RD_REQ: if (ram.Sout_DataRdy) rdata <= ram.Sout_Rdata_ram;
                RD_OUT: if (rd_ready && idx != LAST) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    // bus fields are zeroed whenever no request is active
    assign ram.S_oe_ram        = oe;
    assign ram.S_we_ram        = we;
    assign ram.S_addr_ram      = (oe || we) ? BASE + ADDR_W'({idx, 2'b00}) : '0;
    assign ram.S_Wdata_ram     = we ? word : '0;
    assign ram.S_data_ram_size = (oe || we) ? 7'd32 : 7'd0;

    assign rd_data  = rdata;
    assign rd_index = idx;
    assign cycles   = cyc;
    assign timeout  = tmo;
endmodule
